mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one byte-wide memory port between an instruction
// fetch port (16-bit big-endian word, two byte reads) and a load/store port.
// Round-robin arbitration is done only in IDLE, and the grant is combinational.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   fetch_req/addr -> fetch_gnt        fetch request, address, accept pulse
//   fetch_valid, fetch_instr           completion pulse, fetched word
//   lsu_req/we/addr/wdata -> lsu_gnt   load/store request, accept pulse
//   lsu_done, lsu_rdata                completion pulse, load data
//   mem_addr/wdata/rdata/en/we         shared memory port
//   busy                               FSM not in IDLE
module mem_bus_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [15:0] fetch_instr,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [15:0] lsu_addr,
    input  logic [7:0]  lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_done,
    output logic [7:0]  lsu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        busy
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_HI   = 3'd1,
        F_HI_W = 3'd2,
        F_LO   = 3'd3,
        F_LO_W = 3'd4,
        L_RD   = 3'd5,
        L_RD_W = 3'd6,
        L_WR   = 3'd7
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            last_lsu;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   hi_q;
    logic            is_wait_c;
    logic            wait_last_c;

    assign is_wait_c   = (state == F_HI_W) || (state == F_LO_W) || (state == L_RD_W);
    assign wait_last_c = (cnt == CW'(MEM_LAT - 1));
    assign mem_addr    = addr_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (fetch_gnt) begin
                    state_nx = F_HI;
                end else if (lsu_gnt) begin
                    state_nx = lsu_we ? L_WR : L_RD;
                end
            end
            F_HI:    state_nx = F_HI_W;
            F_HI_W:  if (wait_last_c) state_nx = F_LO;
            F_LO:    state_nx = F_LO_W;
            F_LO_W:  if (wait_last_c) state_nx = IDLE;
            L_RD:    state_nx = L_RD_W;
            L_RD_W:  if (wait_last_c) state_nx = IDLE;
            L_WR:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; grants are gated by rst_n so reset zeroes them too
    always_comb begin
        fetch_gnt = 1'b0;
        lsu_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Tie goes to whoever was not granted last
                fetch_gnt = rst_n && fetch_req && (!lsu_req || last_lsu);
                lsu_gnt   = rst_n && lsu_req && (!fetch_req || !last_lsu);
            end
            F_HI, F_LO, L_RD: begin
                mem_en = 1'b1;
            end
            L_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Wait-state counter: counts 0..MEM_LAT-1 inside each *_W state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (is_wait_c && !wait_last_c) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Request capture, address sequencing and round-robin flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            last_lsu <= 1'b1;
        end else if (fetch_gnt) begin
            addr_q   <= fetch_addr;
            last_lsu <= 1'b0;
        end else if (lsu_gnt) begin
            addr_q   <= lsu_addr;
            wdata_q  <= lsu_wdata;
            last_lsu <= 1'b1;
        end else if (state == F_HI_W && wait_last_c) begin
            // Second byte of the word; wraps 0xFFFF -> 0x0000
            addr_q <= addr_q + AW'(1);
        end
    end

    // Read data capture and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q        <= '0;
            fetch_instr <= '0;
            fetch_valid <= 1'b0;
            lsu_rdata   <= '0;
            lsu_done    <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            lsu_done    <= 1'b0;
            case (state)
                F_HI_W: if (wait_last_c) hi_q <= mem_rdata;
                F_LO_W: begin
                    if (wait_last_c) begin
                        fetch_instr <= {hi_q, mem_rdata};
                        fetch_valid <= 1'b1;
                    end
                end
                L_RD_W: begin
                    if (wait_last_c) begin
                        lsu_rdata <= mem_rdata;
                        lsu_done  <= 1'b1;
                    end
                end
                L_WR:    lsu_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance at MEM_LAT=1, one at
// MEM_LAT=3, each with its own byte-array memory model.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;

    logic        f_req, f_gnt, f_valid;
    logic [15:0] f_addr, f_instr;
    logic        l_req, l_we, l_gnt, l_done;
    logic [15:0] l_addr;
    logic [7:0]  l_wdata, l_rdata;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic        m_en, m_we, busy;

    logic        f3_req, f3_gnt, f3_valid;
    logic [15:0] f3_addr, f3_instr;
    logic        l3_req, l3_we, l3_gnt, l3_done;
    logic [15:0] l3_addr;
    logic [7:0]  l3_wdata, l3_rdata;
    logic [15:0] m3_addr;
    logic [7:0]  m3_wdata, m3_rdata;
    logic        m3_en, m3_we, busy3;

    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(f_req), .fetch_addr(f_addr), .fetch_gnt(f_gnt),
        .fetch_valid(f_valid), .fetch_instr(f_instr),
        .lsu_req(l_req), .lsu_we(l_we), .lsu_addr(l_addr), .lsu_wdata(l_wdata),
        .lsu_gnt(l_gnt), .lsu_done(l_done), .lsu_rdata(l_rdata),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata),
        .mem_en(m_en), .mem_we(m_we), .busy(busy)
    );

    mem_bus_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(f3_req), .fetch_addr(f3_addr), .fetch_gnt(f3_gnt),
        .fetch_valid(f3_valid), .fetch_instr(f3_instr),
        .lsu_req(l3_req), .lsu_we(l3_we), .lsu_addr(l3_addr), .lsu_wdata(l3_wdata),
        .lsu_gnt(l3_gnt), .lsu_done(l3_done), .lsu_rdata(l3_rdata),
        .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
        .mem_en(m3_en), .mem_we(m3_we), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: address is held by the DUT through the wait states
    assign m_rdata  = mem1[m_addr];
    assign m3_rdata = mem3[m3_addr];

    always @(posedge clk) begin
        if (m_en && m_we) mem1[m_addr] = m_wdata;
        if (m3_en && m3_we) mem3[m3_addr] = m3_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 1'b0; l_req = 1'b0; f3_req = 1'b0; l3_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Steps cycles (bounded) until dut1 grants; cyc = -1 on timeout
    task automatic wait_gnt(input int max, output int cyc, output logic gf,
                            output logic gl, output logic fv, output logic ld);
        bit hit;
        hit = 1'b0;
        cyc = -1; gf = 1'b0; gl = 1'b0; fv = 1'b0; ld = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            #1;
            if (f_gnt || l_gnt) begin
                hit = 1'b1;
                cyc = i; gf = f_gnt; gl = l_gnt; fv = f_valid; ld = l_done;
            end else begin
                @(posedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic gf, gl, fv, ld;

        rst_n = 1'b0;
        f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        f3_req = 0; f3_addr = '0; l3_req = 0; l3_we = 0; l3_addr = '0; l3_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[16'h0010] = 8'hA5; mem1[16'h0011] = 8'h3C;
        mem1[16'h0020] = 8'h99;
        mem1[16'hFFFF] = 8'h12; mem1[16'h0000] = 8'h34;
        mem3[16'h0042] = 8'h77;

        // Reset state
        do_reset();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_instr",  32'(f_instr), 0);
        chk("rst_mem_en", 32'(m_en), 0);
        chk("rst_addr",   32'(m_addr), 0);
        chk("rst_busy3",  32'(busy3), 0);

        // Basic fetch at 0x0010, MEM_LAT=1
        f_req = 1; f_addr = 16'h0010;
        #1 chk("f1_gnt", 32'(f_gnt), 1);
        step(); f_req = 0;
        chk("f1_c1_en", 32'(m_en), 1);
        chk("f1_c1_we", 32'(m_we), 0);
        chk("f1_c1_addr", 32'(m_addr), 32'h0010);
        chk("f1_c1_busy", 32'(busy), 1);
        step();
        chk("f1_c2_en", 32'(m_en), 0);
        chk("f1_c2_addr", 32'(m_addr), 32'h0010);
        step();
        chk("f1_c3_en", 32'(m_en), 1);
        chk("f1_c3_addr", 32'(m_addr), 32'h0011);
        step();
        chk("f1_c4_en", 32'(m_en), 0);
        chk("f1_c4_valid", 32'(f_valid), 0);
        step();
        chk("f1_c5_valid", 32'(f_valid), 1);
        chk("f1_c5_instr", 32'(f_instr), 32'hA53C);
        chk("f1_c5_busy", 32'(busy), 0);
        step();
        chk("f1_c6_valid", 32'(f_valid), 0);
        chk("f1_c6_hold", 32'(f_instr), 32'hA53C);

        // Ties after reset: fetch first, then alternate; held requests
        do_reset();
        f_req = 1; f_addr = 16'h0010;
        l_req = 1; l_we = 0; l_addr = 16'h0020;
        wait_gnt(20, cyc, gf, gl, fv, ld);
        chk("rr0_cyc", 32'(cyc), 0);
        chk("rr0_f", 32'(gf), 1);
        chk("rr0_l", 32'(gl), 0);
        step();
        wait_gnt(20, cyc, gf, gl, fv, ld);
        chk("rr1_cyc", 32'(cyc), 4);
        chk("rr1_l", 32'(gl), 1);
        chk("rr1_f", 32'(gf), 0);
        chk("rr1_valid", 32'(fv), 1);
        step();
        wait_gnt(20, cyc, gf, gl, fv, ld);
        chk("rr2_cyc", 32'(cyc), 2);
        chk("rr2_f", 32'(gf), 1);
        chk("rr2_done", 32'(ld), 1);
        chk("rr2_rdata", 32'(l_rdata), 32'h99);
        step();
        wait_gnt(20, cyc, gf, gl, fv, ld);
        chk("rr3_cyc", 32'(cyc), 4);
        chk("rr3_l", 32'(gl), 1);
        chk("rr3_valid", 32'(fv), 1);
        step(); f_req = 0; l_req = 0;
        step(); step();
        chk("rr3_done", 32'(l_done), 1);

        // Store then back-to-back load of the same address
        l_req = 1; l_we = 1; l_addr = 16'h1234; l_wdata = 8'h5A;
        #1 chk("st_gnt", 32'(l_gnt), 1);
        step(); l_req = 0; l_wdata = 8'h00;
        chk("st_en", 32'(m_en), 1);
        chk("st_we", 32'(m_we), 1);
        chk("st_addr", 32'(m_addr), 32'h1234);
        chk("st_wdata", 32'(m_wdata), 32'h5A);
        step();
        chk("st_done", 32'(l_done), 1);
        chk("st_en_off", 32'(m_en), 0);
        chk("st_wdata0", 32'(m_wdata), 0);
        l_req = 1; l_we = 0; l_addr = 16'h1234;
        #1 chk("ld_gnt_b2b", 32'(l_gnt), 1);
        step(); l_req = 0;
        chk("ld_en", 32'(m_en), 1);
        chk("ld_we", 32'(m_we), 0);
        chk("ld_wdata0", 32'(m_wdata), 0);
        step(); step();
        chk("ld_done", 32'(l_done), 1);
        chk("ld_rdata", 32'(l_rdata), 32'h5A);

        // Fetch at 0xFFFF wraps second byte to 0x0000
        f_req = 1; f_addr = 16'hFFFF;
        #1 chk("wr_gnt", 32'(f_gnt), 1);
        step(); f_req = 0;
        chk("wr_c1_addr", 32'(m_addr), 32'hFFFF);
        step(); step();
        chk("wr_c3_en", 32'(m_en), 1);
        chk("wr_c3_addr", 32'(m_addr), 32'h0000);
        step(); step();
        chk("wr_valid", 32'(f_valid), 1);
        chk("wr_instr", 32'(f_instr), 32'h1234);

        // MEM_LAT=3 load
        l3_req = 1; l3_we = 0; l3_addr = 16'h0042;
        #1 chk("l3_gnt", 32'(l3_gnt), 1);
        step(); l3_req = 0;
        chk("l3_c1_en", 32'(m3_en), 1);
        chk("l3_c1_addr", 32'(m3_addr), 32'h0042);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("l3_c%0d_en", c), 32'(m3_en), 0);
            chk($sformatf("l3_c%0d_addr", c), 32'(m3_addr), 32'h0042);
            chk($sformatf("l3_c%0d_done", c), 32'(l3_done), 0);
        end
        step();
        chk("l3_c5_done", 32'(l3_done), 1);
        chk("l3_c5_rdata", 32'(l3_rdata), 32'h77);

        // Reset during F_LO_W aborts the fetch
        f_req = 1; f_addr = 16'h0010;
        #1 chk("ra_gnt", 32'(f_gnt), 1);
        step(); f_req = 0;
        step(); step(); step();
        chk("ra_c4_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ra_busy", 32'(busy), 0);
        chk("ra_en", 32'(m_en), 0);
        chk("ra_addr", 32'(m_addr), 0);
        chk("ra_instr", 32'(f_instr), 0);
        chk("ra_rdata", 32'(l_rdata), 0);
        chk("ra_valid", 32'(f_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("ra_novalid%0d", c), 32'(f_valid), 0);
        end
        f_req = 1; f_addr = 16'h0010;
        #1 chk("ra_regnt", 32'(f_gnt), 1);
        step(); f_req = 0;
        repeat (4) step();
        chk("ra_revalid", 32'(f_valid), 1);
        chk("ra_reinstr", 32'(f_instr), 32'hA53C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
